// File: rtl/hiscore_xfer.sv
// High-score transfer engine: stages a high-score file between the HPS ioctl bus
// and the core's high-score RAM port, restoring after download and dumping on request.
module hiscore_xfer #(
  parameter logic [10:0] HS_START      = 11'h000,
  parameter int          HS_LEN        = 64,
  parameter logic [7:0]  HS_INDEX      = 8'd4,
  parameter logic [23:0] RESTORE_DELAY = 24'd4_915_200
) (
  input  logic        clk_49m,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_data,
  output logic [7:0]  ioctl_din,
  input  logic        save_req,
  output logic [10:0] hs_address,
  output logic [7:0]  hs_data_in,
  input  logic [7:0]  hs_data_out,
  output logic        hs_write,
  output logic        hs_access,
  output logic        pause_req,
  output logic        busy,
  output logic        loaded,
  output logic        dump_done
);

  localparam int AW = (HS_LEN > 1) ? $clog2(HS_LEN) : 1;
  localparam int CW = $clog2(HS_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_PAUSE,
    S_RESTORE,
    S_DUMP
  } state_t;

  state_t         r_state;
  logic           r_dir_dump;
  logic           r_got_data;
  logic           r_dl_d;
  logic [23:0]    r_dly;
  logic [CW-1:0]  r_cnt;
  logic [10:0]    r_hs_address;
  logic [7:0]     r_hs_data_in;
  logic           r_hs_write;
  logic           r_hs_access;
  logic           r_pause;
  logic           r_loaded;
  logic           r_dump_done;
  logic [7:0]     r_ioctl_din;
  logic [7:0]     r_buf [HS_LEN];

  logic           w_dl_fall;
  logic           w_dl_rise;
  logic           w_capture;
  logic           w_up_sel;
  logic           w_up_in_range;
  logic           w_dump_wr;
  logic [AW-1:0]  w_dump_idx;

  assign w_dl_fall     = r_dl_d & ~ioctl_download;
  assign w_dl_rise     = ~r_dl_d & ioctl_download;
  assign w_capture     = ((r_state == S_IDLE) || (r_state == S_DELAY)) &&
                         ioctl_download && (ioctl_index == HS_INDEX) && ioctl_wr &&
                         (ioctl_addr < 25'(HS_LEN));
  assign w_up_sel      = ioctl_upload && (ioctl_index == HS_INDEX);
  assign w_up_in_range = (ioctl_addr < 25'(HS_LEN));
  // Core read data lags the address by one cycle, so DUMP cycle c stores byte c-1.
  assign w_dump_wr     = (r_state == S_DUMP) && (r_cnt != '0);
  assign w_dump_idx    = AW'(r_cnt - CW'(1));

  // Port A write: dump capture and download capture never overlap in state.
  always_ff @(posedge clk_49m) begin
    if (w_dump_wr) begin
      r_buf[w_dump_idx] <= hs_data_out;
    end else if (w_capture) begin
      r_buf[ioctl_addr[AW-1:0]] <= ioctl_data;
    end
  end

  // Port B: upload read path, independent of the state machine.
  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n) begin
      r_ioctl_din <= 8'h00;
    end else if (w_up_sel) begin
      r_ioctl_din <= w_up_in_range ? r_buf[ioctl_addr[AW-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk_49m or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_dir_dump   <= 1'b0;
      r_got_data   <= 1'b0;
      r_dl_d       <= 1'b0;
      r_dly        <= '0;
      r_cnt        <= '0;
      r_hs_address <= '0;
      r_hs_data_in <= '0;
      r_hs_write   <= 1'b0;
      r_hs_access  <= 1'b0;
      r_pause      <= 1'b0;
      r_loaded     <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dl_d      <= ioctl_download;
      r_dump_done <= 1'b0;
      if (w_capture) begin
        r_got_data <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_dl_fall && r_got_data) begin
            r_state    <= S_DELAY;
            r_dly      <= '0;
            r_got_data <= 1'b0;
          end else if (save_req) begin
            r_state    <= S_PAUSE;
            r_dir_dump <= 1'b1;
            r_pause    <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_DELAY: begin
          // A new download restarts the load; the core is left untouched.
          if (w_dl_rise) begin
            r_state <= S_IDLE;
          end else if (r_dly == RESTORE_DELAY - 24'd1) begin
            r_state    <= S_PAUSE;
            r_dir_dump <= 1'b0;
            r_pause    <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_dly <= r_dly + 24'd1;
          end
        end
        S_PAUSE: begin
          if (r_cnt == CW'(1)) begin
            r_cnt <= '0;
            if (r_dir_dump) begin
              r_state      <= S_DUMP;
              r_hs_access  <= 1'b1;
              r_hs_write   <= 1'b0;
              r_hs_data_in <= 8'h00;
              r_hs_address <= HS_START;
            end else begin
              r_state <= S_RESTORE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RESTORE: begin
          // The buffer read of byte i and its presentation on the port share one edge.
          if (r_cnt == CW'(HS_LEN)) begin
            r_state      <= S_IDLE;
            r_hs_access  <= 1'b0;
            r_hs_write   <= 1'b0;
            r_hs_data_in <= 8'h00;
            r_hs_address <= '0;
            r_pause      <= 1'b0;
            r_loaded     <= 1'b1;
            r_cnt        <= '0;
          end else begin
            r_hs_access  <= 1'b1;
            r_hs_write   <= 1'b1;
            r_hs_address <= HS_START + 11'(r_cnt);
            r_hs_data_in <= r_buf[r_cnt[AW-1:0]];
            r_cnt        <= r_cnt + CW'(1);
          end
        end
        S_DUMP: begin
          if (r_cnt == CW'(HS_LEN)) begin
            r_state      <= S_IDLE;
            r_hs_access  <= 1'b0;
            r_hs_address <= '0;
            r_pause      <= 1'b0;
            r_dump_done  <= 1'b1;
            r_cnt        <= '0;
          end else begin
            // The last address is held through the final capture cycle.
            if (r_cnt < CW'(HS_LEN - 1)) begin
              r_hs_address <= r_hs_address + 11'd1;
            end
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ioctl_din  = r_ioctl_din;
  assign hs_address = r_hs_address;
  assign hs_data_in = r_hs_data_in;
  assign hs_write   = r_hs_write;
  assign hs_access  = r_hs_access;
  assign pause_req  = r_pause;
  assign busy       = (r_state != S_IDLE);
  assign loaded     = r_loaded;
  assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_hiscore_xfer.sv
// Scenario bench for hiscore_xfer: restore, dump/upload, filtering, reset and restart.
module tb_hiscore_xfer;

  localparam int          HS_LEN        = 16;
  localparam logic [10:0] HS_START      = 11'h100;
  localparam logic [7:0]  HS_INDEX      = 8'd4;
  localparam logic [23:0] RESTORE_DELAY = 24'd8;

  logic        clk_49m = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_wr;
  logic [7:0]  ioctl_data;
  logic [7:0]  ioctl_din;
  logic        save_req;
  logic [10:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out = 8'h00;
  logic        hs_write;
  logic        hs_access;
  logic        pause_req;
  logic        busy;
  logic        loaded;
  logic        dump_done;

  logic [18:0] exp_q[$];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk_49m = ~clk_49m;

  hiscore_xfer #(
    .HS_START(HS_START), .HS_LEN(HS_LEN), .HS_INDEX(HS_INDEX), .RESTORE_DELAY(RESTORE_DELAY)
  ) dut (
    .clk_49m(clk_49m), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
    .ioctl_wr(ioctl_wr), .ioctl_data(ioctl_data), .ioctl_din(ioctl_din),
    .save_req(save_req), .hs_address(hs_address), .hs_data_in(hs_data_in),
    .hs_data_out(hs_data_out), .hs_write(hs_write), .hs_access(hs_access),
    .pause_req(pause_req), .busy(busy), .loaded(loaded), .dump_done(dump_done)
  );

  // Core high-score RAM model: registered read, one cycle after the address.
  logic [7:0] core_ram [2048];
  logic       core_fill = 1'b0;
  always @(posedge clk_49m) begin
    if (core_fill) begin
      for (int i = 0; i < 2048; i++) core_ram[i] <= 8'(i - 'hB0);
    end else if (hs_access && hs_write) begin
      core_ram[hs_address] <= hs_data_in;
    end
    if (hs_access) hs_data_out <= core_ram[hs_address];
  end

  task automatic download(input logic [7:0] idx, input int a0, input int n,
                          input logic [7:0] d0, input bit expect_wr);
    ioctl_download = 1'b1;
    ioctl_index    = idx;
    for (int i = 0; i < n; i++) begin
      ioctl_addr = 25'(a0 + i);
      ioctl_data = d0 + 8'(i);
      ioctl_wr   = 1'b1;
      if (expect_wr) exp_q.push_back({HS_START + 11'(a0 + i), d0 + 8'(i)});
      @(negedge clk_49m);
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
  endtask

  task automatic observe_restore(input int save_at);
    int cyc;
    int nwr;
    logic [18:0] e;
    @(negedge clk_49m);
    n_total++;
    if (busy !== 1'b1) $display("FAIL restore_busy: got %b required 1", busy);
    else n_pass++;
    cyc = 0;
    while (pause_req !== 1'b1 && cyc < 100) begin @(negedge clk_49m); cyc++; end
    n_total++;
    if (cyc != int'(RESTORE_DELAY)) $display("FAIL restore_delay: got %0d cycles required %0d", cyc, RESTORE_DELAY);
    else n_pass++;
    cyc = 0;
    while (!(hs_access === 1'b1 && hs_write === 1'b1) && cyc < 20) begin @(negedge clk_49m); cyc++; end
    n_total++;
    if (cyc != 3) $display("FAIL restore_settle: got %0d cycles required 3", cyc);
    else n_pass++;
    nwr = 0;
    while (hs_access === 1'b1 && hs_write === 1'b1 && nwr < HS_LEN + 4) begin
      save_req = (nwr == save_at);
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL restore_write: got unexpected write %h:%h", hs_address, hs_data_in);
      end else begin
        e = exp_q.pop_front();
        if ({hs_address, hs_data_in} !== e || pause_req !== 1'b1)
          $display("FAIL restore_write: got %h:%h pause %b required %h:%h pause 1",
                   hs_address, hs_data_in, pause_req, e[18:8], e[7:0]);
        else n_pass++;
      end
      nwr++;
      @(negedge clk_49m);
    end
    save_req = 1'b0;
    n_total++;
    if (nwr != HS_LEN) $display("FAIL restore_count: got %0d writes required %0d", nwr, HS_LEN);
    else n_pass++;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL restore_missing: got %0d left required 0", exp_q.size());
    else n_pass++;
    exp_q.delete();
    n_total++;
    if ({hs_access, hs_write, hs_data_in, pause_req, busy, loaded} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1})
      $display("FAIL restore_end: got acc %b wr %b din %h pause %b busy %b loaded %b required 0 0 00 0 0 1",
               hs_access, hs_write, hs_data_in, pause_req, busy, loaded);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_addr = '0; ioctl_wr = 1'b0; ioctl_data = 8'h00; save_req = 1'b0;
    repeat (3) @(negedge clk_49m);
    n_total++;
    if ({ioctl_din, hs_address, hs_data_in, hs_write, hs_access, pause_req, busy, loaded, dump_done} !== 33'd0)
      $display("FAIL reset_outputs: got %h required 0",
               {ioctl_din, hs_address, hs_data_in, hs_write, hs_access, pause_req, busy, loaded, dump_done});
    else n_pass++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk_49m);
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_idle: got busy %b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_restore();
    download(HS_INDEX, 0, HS_LEN, 8'hA0, 1'b1);
    observe_restore(-1);
  endtask

  task automatic test_dump();
    int cyc;
    int n_acc;
    int bad;
    logic [18:0] e;
    core_fill = 1'b1;
    @(negedge clk_49m);
    core_fill = 1'b0;
    for (int i = 0; i < HS_LEN; i++) exp_q.push_back(19'(8'h50 + 8'(i)));
    save_req = 1'b1;
    @(negedge clk_49m);
    save_req = 1'b0;
    cyc = 0;
    while (hs_access !== 1'b1 && cyc < 20) begin @(negedge clk_49m); cyc++; end
    n_access_loop: begin
      n_acc = 0; bad = 0;
      while (hs_access === 1'b1 && n_acc < 40) begin
        if (hs_write !== 1'b0 || hs_data_in !== 8'h00 || pause_req !== 1'b1) bad++;
        n_acc++;
        @(negedge clk_49m);
      end
    end
    n_total++;
    if (n_acc != HS_LEN + 1) $display("FAIL dump_access: got %0d cycles required %0d", n_acc, HS_LEN + 1);
    else n_pass++;
    n_total++;
    if (bad != 0) $display("FAIL dump_readonly: got %0d bad cycles required 0", bad);
    else n_pass++;
    n_total++;
    if (dump_done !== 1'b1 || pause_req !== 1'b0) $display("FAIL dump_done: got %b pause %b required 1 0", dump_done, pause_req);
    else n_pass++;
    @(negedge clk_49m);
    n_total++;
    if (dump_done !== 1'b0 || busy !== 1'b0) $display("FAIL dump_pulse: got done %b busy %b required 0 0", dump_done, busy);
    else n_pass++;
    ioctl_upload = 1'b1;
    ioctl_index  = HS_INDEX;
    for (int i = 0; i < HS_LEN; i++) begin
      ioctl_addr = 25'(i);
      @(negedge clk_49m);
      e = exp_q.pop_front();
      n_total++;
      if (ioctl_din !== e[7:0]) $display("FAIL upload_byte: addr %0d got %h required %h", i, ioctl_din, e[7:0]);
      else n_pass++;
    end
    ioctl_addr = 25'd20;
    @(negedge clk_49m);
    n_total++;
    if (ioctl_din !== 8'h00) $display("FAIL upload_oob: got %h required 00", ioctl_din);
    else n_pass++;
    ioctl_upload = 1'b0;
  endtask

  task automatic test_ignored_downloads();
    int n_busy;
    download(8'd3, 0, HS_LEN, 8'hE0, 1'b0);
    @(negedge clk_49m);
    download(HS_INDEX, HS_LEN, HS_LEN, 8'hF0, 1'b0);
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_49m);
      if (busy !== 1'b0 || hs_access !== 1'b0) n_busy++;
    end
    n_total++;
    if (n_busy != 0) $display("FAIL ignored_busy: got %0d busy cycles required 0", n_busy);
    else n_pass++;
    for (int i = 0; i < HS_LEN; i++) exp_q.push_back(19'(8'h50 + 8'(i)));
    ioctl_upload = 1'b1;
    ioctl_index  = HS_INDEX;
    for (int i = 0; i < HS_LEN; i++) begin
      logic [18:0] e;
      ioctl_addr = 25'(i);
      @(negedge clk_49m);
      e = exp_q.pop_front();
      n_total++;
      if (ioctl_din !== e[7:0]) $display("FAIL ignored_buffer: addr %0d got %h required %h", i, ioctl_din, e[7:0]);
      else n_pass++;
    end
    ioctl_upload = 1'b0;
  endtask

  task automatic test_save_during_restore();
    int n_bad;
    download(HS_INDEX, 0, HS_LEN, 8'h30, 1'b1);
    observe_restore(3);
    n_bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (dump_done !== 1'b0 || busy !== 1'b0) n_bad++;
      @(negedge clk_49m);
    end
    n_total++;
    if (n_bad != 0) $display("FAIL save_ignored: got %0d dump/busy cycles required 0", n_bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    download(HS_INDEX, 0, HS_LEN, 8'hC0, 1'b0);
    cyc = 0;
    while (!(hs_write === 1'b1 && hs_address === HS_START + 11'd5) && cyc < 100) begin
      @(negedge clk_49m); cyc++;
    end
    n_total++;
    if (cyc >= 100) $display("FAIL midreset_reach: got timeout required write 5");
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({hs_access, hs_write, pause_req, busy, loaded} !== 5'b0)
      $display("FAIL midreset_outputs: got %b required 00000", {hs_access, hs_write, pause_req, busy, loaded});
    else n_pass++;
    @(negedge clk_49m);
    reset_n = 1'b1;
    @(negedge clk_49m);
    save_req = 1'b1;
    @(negedge clk_49m);
    save_req = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL midreset_save: got busy %b required 1", busy);
    else n_pass++;
    cyc = 0;
    while (dump_done !== 1'b1 && cyc < 60) begin @(negedge clk_49m); cyc++; end
    n_total++;
    if (cyc >= 60 || loaded !== 1'b0) $display("FAIL midreset_dump: got cycles %0d loaded %b required <60 0", cyc, loaded);
    else n_pass++;
    @(negedge clk_49m);
  endtask

  task automatic test_restart_delay();
    download(HS_INDEX, 0, HS_LEN, 8'h11, 1'b0);
    @(negedge clk_49m);
    n_total++;
    if (busy !== 1'b1) $display("FAIL restart_delay_entry: got busy %b required 1", busy);
    else n_pass++;
    repeat (4) @(negedge clk_49m);
    ioctl_download = 1'b1;
    ioctl_index    = HS_INDEX;
    @(negedge clk_49m);
    n_total++;
    if (busy !== 1'b0 || pause_req !== 1'b0 || hs_access !== 1'b0)
      $display("FAIL restart_abort: got busy %b pause %b acc %b required 0 0 0", busy, pause_req, hs_access);
    else n_pass++;
    download(HS_INDEX, 0, HS_LEN, 8'h70, 1'b1);
    observe_restore(-1);
  endtask

  initial begin
    test_reset();
    test_restore();
    test_dump();
    test_ignored_downloads();
    test_save_during_restore();
    test_reset_mid();
    test_restart_delay();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
